// File: rtl/sed_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sed_pkg : shared state encoding and constants for the SED supervisor |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sed_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    READY  = 3'd2,
    START  = 3'd3,
    BUSY   = 3'd4,
    EVAL   = 3'd5,
    GAP    = 3'd6
  } sed_state_e;

  localparam int unsigned C_MIN_GAP = 16;

  function automatic int unsigned eff_gap(input int unsigned gap);
    return (gap < C_MIN_GAP) ? C_MIN_GAP : gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for one asynchronous status bit     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/sed_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sed_supervisor : sequences SED primitive scans, confirms errors,     |
// | detects hung scans and keeps scan/error statistics.  Rev 1.0         |
// +----------------------------------------------------------------------+
module sed_supervisor
  import sed_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 128,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CONFIRM_SCANS  = 2,
  parameter int unsigned CNT_W          = 16,
  parameter bit          CONTINUOUS     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             sed_err_i,
  input  logic             sed_done_i,
  input  logic             sed_inprog_i,
  output logic             sed_enable_o,
  output logic             sed_start_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] scan_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned c_startup = (STARTUP_CYCLES == 0) ? 1 : STARTUP_CYCLES;
  localparam int unsigned c_gap     = eff_gap(GAP_CYCLES);
  localparam int unsigned c_timeout = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned c_ph_max  = (c_startup > c_gap) ? c_startup : c_gap;
  localparam int unsigned c_ph_w    = $clog2(c_ph_max + 1);
  localparam int unsigned c_tmo_w   = $clog2(c_timeout + 1);
  localparam logic [3:0]  c_confirm = 4'(CONFIRM_SCANS);

  sed_state_e         r_state;
  sed_state_e         w_next;
  logic [c_ph_w-1:0]  r_ph;
  logic [c_tmo_w-1:0] r_tmo;
  logic               r_kill;
  logic               r_err;
  logic               r_timeout;
  logic [3:0]         r_streak;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic [CNT_W-1:0]   r_err_cnt;

  logic err_s, done_s, inprog_s;
  logic w_warm_end, w_gap_end, w_scanning, w_tmo_set, w_eval, w_confirm;
  logic [3:0] w_streak_inc;

  sync_2ff u_sync_err    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(sed_err_i),    .q_o(err_s));
  sync_2ff u_sync_done   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(sed_done_i),   .q_o(done_s));
  sync_2ff u_sync_inprog (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(sed_inprog_i), .q_o(inprog_s));

  assign w_warm_end   = (r_ph == c_ph_w'(c_startup - 1));
  assign w_gap_end    = (r_ph == c_ph_w'(c_gap - 1));
  assign w_scanning   = (r_state == START) || (r_state == BUSY);
  assign w_tmo_set    = enable_i && w_scanning && (r_tmo == c_tmo_w'(c_timeout - 1));
  assign w_eval       = enable_i && (r_state == EVAL);
  assign w_streak_inc = r_streak + 4'd1;
  assign w_confirm    = w_eval && err_s && (w_streak_inc == c_confirm);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    sed_enable_o = (r_state != IDLE) && !r_kill;
    sed_start_o  = (r_state == START);
    busy_o       = (r_state == START) || (r_state == BUSY) || (r_state == EVAL);
    unique case (r_state)
      IDLE:    if (enable_i) w_next = WARMUP;
      WARMUP:  if (w_warm_end) w_next = CONTINUOUS ? START : READY;
      READY:   if (start_i) w_next = START;
      START: begin
        if (w_tmo_set)     w_next = WARMUP;
        else if (inprog_s) w_next = BUSY;
      end
      BUSY: begin
        if (w_tmo_set)                w_next = WARMUP;
        else if (done_s && !inprog_s) w_next = EVAL;
      end
      EVAL:    w_next = GAP;
      GAP:     if (w_gap_end) w_next = CONTINUOUS ? START : READY;
      default: w_next = IDLE;
    endcase
    if (!enable_i) w_next = IDLE;
  end

  // Phase counter times WARMUP and GAP; restarts on every state change.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ph       <= '0;
      r_tmo      <= '0;
      r_kill     <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_streak   <= '0;
      r_scan_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if ((w_next != r_state) || !((r_state == WARMUP) || (r_state == GAP)))
        r_ph <= '0;
      else
        r_ph <= r_ph + c_ph_w'(1);

      if (w_scanning && ((w_next == START) || (w_next == BUSY)))
        r_tmo <= r_tmo + c_tmo_w'(1);
      else
        r_tmo <= '0;

      r_kill <= w_tmo_set;

      // Set events take priority over a simultaneous clear.
      if (w_confirm)    r_err <= 1'b1;
      else if (clear_i) r_err <= 1'b0;

      if (w_tmo_set)    r_timeout <= 1'b1;
      else if (clear_i) r_timeout <= 1'b0;

      if (!enable_i)    r_streak <= '0;
      else if (w_eval)  r_streak <= (err_s && !w_confirm) ? w_streak_inc : 4'd0;
      else if (clear_i) r_streak <= '0;

      if (w_eval && (r_scan_cnt != {CNT_W{1'b1}}))
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);

      if (w_confirm && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_o      = r_err;
  assign timeout_o  = r_timeout;
  assign scan_cnt_o = r_scan_cnt;
  assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sed_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sed_supervisor : four supervisor configurations, each driven by a |
// | behavioural SED primitive model, checked through a scoreboard.       |
// +----------------------------------------------------------------------+
module tb_sed_supervisor;

  typedef struct packed {
    logic [15:0] scan;
    logic [15:0] errc;
    logic        err;
    logic        tmo;
  } res_t;

  // Primitive model timing per instance: done N cycles after start seen.
  localparam int       c_dly [4] = '{200, 200, 100, 5};
  localparam bit [3:0] c_never   = 4'b0010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  en, start, clr;
  logic [31:0] err_mask [4];
  wire  [3:0]  m_err, m_done, m_inprog;
  wire  [31:0] m_nscan [4];
  wire  [3:0]  sed_en, sed_start, busy, err, tmo;
  wire  [15:0] scan_cnt [4];
  wire  [15:0] err_cnt  [4];
  wire  [3:0]  scan_d, errc_d;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q [4][$];

  sed_supervisor u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[0]), .start_i(start[0]), .clear_i(clr[0]),
    .sed_err_i(m_err[0]), .sed_done_i(m_done[0]), .sed_inprog_i(m_inprog[0]),
    .sed_enable_o(sed_en[0]), .sed_start_o(sed_start[0]), .busy_o(busy[0]), .err_o(err[0]),
    .timeout_o(tmo[0]), .scan_cnt_o(scan_cnt[0]), .err_cnt_o(err_cnt[0]));

  sed_supervisor #(.TIMEOUT_CYCLES(1000)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[1]), .start_i(start[1]), .clear_i(clr[1]),
    .sed_err_i(m_err[1]), .sed_done_i(m_done[1]), .sed_inprog_i(m_inprog[1]),
    .sed_enable_o(sed_en[1]), .sed_start_o(sed_start[1]), .busy_o(busy[1]), .err_o(err[1]),
    .timeout_o(tmo[1]), .scan_cnt_o(scan_cnt[1]), .err_cnt_o(err_cnt[1]));

  sed_supervisor #(.STARTUP_CYCLES(20), .CONTINUOUS(1'b0)) u_dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[2]), .start_i(start[2]), .clear_i(clr[2]),
    .sed_err_i(m_err[2]), .sed_done_i(m_done[2]), .sed_inprog_i(m_inprog[2]),
    .sed_enable_o(sed_en[2]), .sed_start_o(sed_start[2]), .busy_o(busy[2]), .err_o(err[2]),
    .timeout_o(tmo[2]), .scan_cnt_o(scan_cnt[2]), .err_cnt_o(err_cnt[2]));

  sed_supervisor #(.STARTUP_CYCLES(4), .GAP_CYCLES(8), .CNT_W(4)) u_dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[3]), .start_i(start[3]), .clear_i(clr[3]),
    .sed_err_i(m_err[3]), .sed_done_i(m_done[3]), .sed_inprog_i(m_inprog[3]),
    .sed_enable_o(sed_en[3]), .sed_start_o(sed_start[3]), .busy_o(busy[3]), .err_o(err[3]),
    .timeout_o(tmo[3]), .scan_cnt_o(scan_d), .err_cnt_o(errc_d));

  assign scan_cnt[3] = {12'd0, scan_d};
  assign err_cnt[3]  = {12'd0, errc_d};

  for (genvar k = 0; k < 4; k++) begin : g_model
    logic r_done, r_inprog, r_errq, r_act;
    int   r_cnt, r_ns;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_done <= 1'b0; r_inprog <= 1'b0; r_errq <= 1'b0; r_act <= 1'b0;
        r_cnt  <= 0;    r_ns     <= 0;
      end else if (!sed_en[k]) begin
        r_done <= 1'b0; r_inprog <= 1'b0; r_errq <= 1'b0; r_act <= 1'b0; r_cnt <= 0;
      end else if (sed_start[k] && !r_act) begin
        r_act <= 1'b1; r_cnt <= 0; r_done <= 1'b0; r_errq <= 1'b0;
        r_inprog <= !c_never[k];
      end else if (r_act && !c_never[k]) begin
        r_cnt <= r_cnt + 1;
        if (r_cnt == c_dly[k] - 1) begin
          r_act <= 1'b0; r_inprog <= 1'b0; r_done <= 1'b1;
          r_errq <= err_mask[k][r_ns + 1];
          r_ns <= r_ns + 1;
        end
      end
    end
    assign m_done[k]   = r_done;
    assign m_inprog[k] = r_inprog;
    assign m_err[k]    = r_errq;
    assign m_nscan[k]  = r_ns;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic push(input int k, input int s, input int ec, input bit e, input bit t);
    res_t r;
    r.scan = 16'(s);
    r.errc = 16'(ec);
    r.err  = e;
    r.tmo  = t;
    exp_q[k].push_back(r);
  endtask

  task automatic wait_q(input int k, input int budget);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q[k].size() != 0) begin
      total++;
      bad++;
      $display("FAIL dut%0d scan_wait: %0d results still pending after %0d cycles", k, exp_q[k].size(), budget);
      exp_q[k].delete();
    end
  endtask

  // A scan ends (in any way) when busy_o drops; compare the counters and flags then.
  task automatic monitor();
    logic [3:0] prev;
    res_t a, e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (prev[k] && !busy[k]) begin
          a.scan = scan_cnt[k]; a.errc = err_cnt[k]; a.err = err[k]; a.tmo = tmo[k];
          total++;
          if (exp_q[k].size() == 0) begin
            bad++;
            $display("FAIL dut%0d unexpected_scan_end: scan=%0d errc=%0d err=%0b tmo=%0b", k, a.scan, a.errc, a.err, a.tmo);
          end else begin
            e = exp_q[k].pop_front();
            if (a !== e) begin
              bad++;
              $display("FAIL dut%0d scan_end: got scan=%0d errc=%0d err=%0b tmo=%0b required scan=%0d errc=%0d err=%0b tmo=%0b",
                       k, a.scan, a.errc, a.err, a.tmo, e.scan, e.errc, e.err, e.tmo);
            end
          end
        end
      end
      prev = busy;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en = '0; start = '0; clr = '0;
    err_mask[0] = 32'h0000_01E8;  // scans 3,5,6,7,8 see err
    err_mask[1] = '0;
    err_mask[2] = '0;
    err_mask[3] = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("dut%0d reset_outputs", k),
          {sed_en[k], sed_start[k], busy[k], err[k], tmo[k], scan_cnt[k], err_cnt[k]}, '0);
    rst_n = 1'b1;
    tick(); tick();
    chk("dut0 idle_after_reset", {sed_en[0], busy[0], scan_cnt[0]}, '0);

    // ---- A: defaults, error confirmation, clear, disable mid-scan ----
    for (int s = 1; s <= 6; s++) push(0, s, (s == 6) ? 1 : 0, s == 6, 1'b0);
    en[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!sed_start[0] && n < 1000);
    chk("dut0 first_start_latency", n, 129);
    wait_q(0, 3000);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0; tick();
    chk("dut0 err_after_clear", err[0], 1'b0);
    chk("dut0 errcnt_kept_after_clear", err_cnt[0], 1);
    chk("dut0 scancnt_kept_after_clear", scan_cnt[0], 6);
    push(0, 7, 1, 1'b0, 1'b0);
    push(0, 8, 2, 1'b1, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!(m_done[0] && m_nscan[0] == 8) && n < 2000);
    chk("dut0 scan8_done_seen", n < 2000, 1'b1);
    repeat (3) tick();  // done crosses the synchronizer; EVAL is the next cycle
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    wait_q(0, 1000);
    push(0, 8, 2, 1'b1, 1'b0);
    n = 0;
    while (!m_inprog[0] && n < 500) begin tick(); n++; end
    repeat (50) tick();
    en[0] = 1'b0;
    tick();
    chk("dut0 disable_outputs", {sed_en[0], sed_start[0], busy[0]}, 3'b000);
    chk("dut0 err_kept_over_disable", err[0], 1'b1);
    wait_q(0, 10);
    repeat (20) tick();
    chk("dut0 scancnt_after_disable", scan_cnt[0], 8);

    // ---- B: primitive never starts, timeout recovery ----
    push(1, 0, 0, 1'b0, 1'b1);
    en[1] = 1'b1;
    n = 0;
    while (!busy[1] && n < 500) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (busy[1] && n < 2000);
    chk("dut1 cycles_to_timeout", n, 1000);
    chk("dut1 enable_dropped_and_timeout", {sed_en[1], tmo[1]}, 2'b01);
    n = 1;
    tick();
    chk("dut1 enable_back_after_one_cycle", sed_en[1], 1'b1);
    do begin tick(); n++; end while (!sed_start[1] && n < 1000);
    chk("dut1 warmup_restart_to_start", n, 128);
    push(1, 0, 0, 1'b0, 1'b1);
    en[1] = 1'b0;
    tick();
    wait_q(1, 10);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    chk("dut1 timeout_cleared", tmo[1], 1'b0);

    // ---- C: single-shot scans on start_i ----
    en[2] = 1'b1;
    n = 0;
    repeat (40) begin tick(); if (sed_start[2]) n++; end
    chk("dut2 no_scan_without_start", n, 0);
    push(2, 1, 0, 1'b0, 1'b0);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    n = 0;
    while (!m_inprog[2] && n < 100) begin tick(); n++; end
    repeat (10) tick();
    start[2] = 1'b1; tick(); start[2] = 1'b0;  // lands in BUSY, must be ignored
    wait_q(2, 1000);
    repeat (60) tick();
    chk("dut2 idle_in_ready", {busy[2], scan_cnt[2]}, {1'b0, 16'd1});
    push(2, 2, 0, 1'b0, 1'b0);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    wait_q(2, 1000);
    en[2] = 1'b0;
    tick();

    // ---- D: 4-bit counters saturate, minimum gap enforced ----
    for (int s = 1; s <= 20; s++) push(3, (s > 15) ? 15 : s, 0, 1'b0, 1'b0);
    en[3] = 1'b1;
    n = 0;
    while (!busy[3] && n < 200) begin tick(); n++; end
    n = 0;
    while (busy[3] && n < 200) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!busy[3] && n < 200);
    chk("dut3 gap_cycles", n, 16);
    wait_q(3, 3000);
    en[3] = 1'b0;
    tick();
    chk("dut3 scancnt_saturated", scan_cnt[3], 15);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
